for_loop3_rev: RTL

FOR_LOOP3_REV -- requirements
Module: for_loop3_rev

---
 rtl/for_loop3_rev_pkg.sv | 12 +
 rtl/for_loop3_rev_loop_down_ctr.sv | 43 ++++
 rtl/for_loop3_rev.sv | 100 ++++++++++
 3 files changed

// File: rtl/for_loop3_rev_pkg.sv
// Shared loop-sequencer definitions: default index width and FSM encodings.
package for_loop3_rev_pkg;

  // Default width of every bound and index.
  localparam int unsigned LOOP_W_DEF = 8;

  // Sequencer states, one state register per block.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/for_loop3_rev_loop_down_ctr.sv
// W-bit down counter with reload. A dec on zero reloads instead of wrapping,
// so (dec & is_zero) acts as the borrow into the next outer counter.
module loop_down_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         is_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats dec; dec at zero reloads val.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = val;
    end else if (dec) begin
      cnt_d = (cnt_q == '0) ? val : cnt_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/for_loop3_rev.sv
// Reverse triple-nested loop index sequencer: walks i, j, k from bound-1
// down to 0 (k innermost), one tuple per accepted handshake.
//
// Handshake: a tuple is transferred on a posedge where idx_valid=1 and
// idx_ready=1. idx_valid depends only on state, never on idx_ready, and
// idx_* / idx_valid hold steady while idx_ready=0.
module for_loop3_rev
  import for_loop3_rev_pkg::*;
#(
  parameter int unsigned W = LOOP_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bound_i,
  input  logic [W-1:0] bound_j,
  input  logic [W-1:0] bound_k,
  input  logic         idx_ready,
  output logic         idx_valid,
  output logic [W-1:0] idx_i,
  output logic [W-1:0] idx_j,
  output logic [W-1:0] idx_k,
  output logic         busy,
  output logic         finish,
  output logic [1:0]   dbg_state
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] bi_q, bi_d;
  logic [W-1:0] bj_q, bj_d;
  logic [W-1:0] bk_q, bk_d;

  logic         launch, all_nz, adv, last;
  logic         ctr_load, ctr_clr;
  logic [W-1:0] val_i, val_j, val_k;
  logic         zero_i, zero_j, zero_k;

  // Handshake gating, launch decode and next-state / bound-latch logic.
  always_comb begin
    launch   = start && (state_q != ST_RUN);
    all_nz   = (bound_i != '0) && (bound_j != '0) && (bound_k != '0);
    adv      = (state_q == ST_RUN) && idx_ready;
    last     = adv && zero_i && zero_j && zero_k;
    ctr_load = launch && all_nz;
    ctr_clr  = (launch && !all_nz) || last;
    // On launch the counters load straight from the inputs (latches not yet
    // valid); afterwards reloads come from the latched bounds.
    val_i    = launch ? bound_i - W'(1) : bi_q - W'(1);
    val_j    = launch ? bound_j - W'(1) : bj_q - W'(1);
    val_k    = launch ? bound_k - W'(1) : bk_q - W'(1);
    state_d  = state_q;
    bi_d     = bi_q;
    bj_d     = bj_q;
    bk_d     = bk_q;
    if (launch) begin
      state_d = all_nz ? ST_RUN : ST_DONE;
      bi_d    = bound_i;
      bj_d    = bound_j;
      bk_d    = bound_k;
    end else if (last) begin
      state_d = ST_DONE;
    end
  end

  // State register and bound latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bi_q    <= '0;
      bj_q    <= '0;
      bk_q    <= '0;
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      bj_q    <= bj_d;
      bk_q    <= bk_d;
    end
  end

  loop_down_ctr #(.W(W)) u_ctr_k (
    .clk(clk), .rst(rst), .clr(ctr_clr), .load(ctr_load),
    .dec(adv), .val(val_k), .cnt(idx_k), .is_zero(zero_k)
  );

  loop_down_ctr #(.W(W)) u_ctr_j (
    .clk(clk), .rst(rst), .clr(ctr_clr), .load(ctr_load),
    .dec(adv && zero_k), .val(val_j), .cnt(idx_j), .is_zero(zero_j)
  );

  loop_down_ctr #(.W(W)) u_ctr_i (
    .clk(clk), .rst(rst), .clr(ctr_clr), .load(ctr_load),
    .dec(adv && zero_k && zero_j), .val(val_i), .cnt(idx_i), .is_zero(zero_i)
  );

  assign idx_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign finish    = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
